// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, frame length, command bytes.
// Also provides the odd-parity helper used when a byte is latched for sending.
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StSend,
        StWaitRel
    } ps2_state_e;

    localparam int unsigned PS2_FRAME_BITS = 11;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 line plus a one-cycle falling-edge strobe.
// Flops reset to 1 so an idle-high line never produces a spurious edge after reset.
module ps2_line_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic sync_o,
    output logic fall_o
);

    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain clock/data pull-low enables.
// The device generates all frame clocks once the host releases the clock after the start bit.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clkKeyboard,
    input  logic       data,
    input  logic       txStart,
    input  logic [7:0] txData,
    output logic       clkKeyboardOe,
    output logic       dataOe,
    output logic       busy,
    output logic       done,
    output logic       ackErr
);

    localparam int unsigned InhW = $clog2(INHIBIT_CYCLES);
    localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES);

    logic kclk_sync, kclk_fall, data_sync, unused_data_fall;

    ps2_line_sync u_clk_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .line_i (clkKeyboard),
        .sync_o (kclk_sync),
        .fall_o (kclk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .line_i (data),
        .sync_o (data_sync),
        .fall_o (unused_data_fall)
    );

    ps2_state_e       state_q, state_d;
    logic [7:0]       tx_q, tx_d;
    logic             parity_q, parity_d;
    logic [InhW-1:0]  inh_cnt_q, inh_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [WdW-1:0]   wd_q, wd_d;
    logic             ack_ok_q, ack_ok_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ack_err_q, ack_err_d;

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        parity_d  = parity_q;
        inh_cnt_d = inh_cnt_q;
        bit_cnt_d = bit_cnt_q;
        wd_d      = wd_q;
        ack_ok_d  = ack_ok_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (txStart) begin
                    tx_d      = txData;
                    parity_d  = odd_parity(txData);
                    inh_cnt_d = '0;
                    bit_cnt_d = '0;
                    wd_d      = '0;
                    ack_ok_d  = 1'b0;
                    busy_d    = 1'b1;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    state_d   = StInhibit;
                end
            end
            StInhibit: begin
                if (inh_cnt_q == InhW'(INHIBIT_CYCLES - 1)) begin
                    data_oe_d = 1'b1;
                    state_d   = StReq;
                end else begin
                    inh_cnt_d = inh_cnt_q + InhW'(1);
                end
            end
            StReq: begin
                clk_oe_d  = 1'b0;
                bit_cnt_d = '0;
                wd_d      = '0;
                state_d   = StSend;
            end
            StSend: begin
                wd_d = wd_q + WdW'(1);
                if (kclk_fall) begin
                    // The last device edge carries the ACK instead of advancing the count.
                    if (bit_cnt_q == 4'(PS2_FRAME_BITS - 1)) begin
                        ack_ok_d = ~data_sync;
                        state_d  = StWaitRel;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q < 4'd8) begin
                            data_oe_d = ~tx_q[bit_cnt_q[2:0]];
                        end else if (bit_cnt_q == 4'd8) begin
                            data_oe_d = ~parity_q;
                        end else begin
                            data_oe_d = 1'b0;
                        end
                    end
                end
            end
            StWaitRel: begin
                wd_d = wd_q + WdW'(1);
                if (kclk_sync && data_sync) begin
                    busy_d    = 1'b0;
                    done_d    = ack_ok_q;
                    ack_err_d = ~ack_ok_q;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Watchdog overrides any same-cycle ACK decision or normal completion.
        if ((state_q == StSend || state_q == StWaitRel) &&
            wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            ack_err_d = 1'b1;
            state_d   = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            tx_q      <= '0;
            parity_q  <= 1'b0;
            inh_cnt_q <= '0;
            bit_cnt_q <= '0;
            wd_q      <= '0;
            ack_ok_q  <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            parity_q  <= parity_d;
            inh_cnt_q <= inh_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            wd_q      <= wd_d;
            ack_ok_q  <= ack_ok_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign clkKeyboardOe = clk_oe_q;
    assign dataOe        = data_oe_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign ackErr        = ack_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks out each frame over open-drain lines,
// and recorded frames and status pulses are compared with hand-computed expectations.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned INH = 8;
    localparam int unsigned TMO = 4000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       kbd_clk_line, kbd_data_line;
    logic       clk_oe, data_oe, busy, done, ack_err;

    assign kbd_clk_line  = ~(clk_oe | dev_clk_low);
    assign kbd_data_line = ~(data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clkKeyboard   (kbd_clk_line),
        .data          (kbd_data_line),
        .txStart       (tx_start),
        .txData        (tx_data),
        .clkKeyboardOe (clk_oe),
        .dataOe        (data_oe),
        .busy          (busy),
        .done          (done),
        .ackErr        (ack_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n_done = 0;
    int n_err = 0;
    int n_both = 0;

    always @(negedge clk) begin
        if (done === 1'b1) n_done++;
        if (ack_err === 1'b1) n_err++;
        if (done === 1'b1 && ack_err === 1'b1) n_both++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         inject;
        logic       exp_par;
    } vec_t;

    vec_t vecs[6];

    // Start a frame, check inhibit/REQ timing, then play the device for 11 clocks.
    task automatic run_vec(input vec_t v);
        int          d0, e0;
        logic [10:0] frame;
        logic [10:0] exp_frame;
        bit          ok;
        d0 = n_done;
        e0 = n_err;
        tx_data  = v.data;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        ok = (busy === 1'b1);
        for (int i = 0; i < int'(INH); i++) begin
            ok &= (clk_oe === 1'b1) && (data_oe === 1'b0);
            tick();
        end
        ok &= (clk_oe === 1'b1) && (data_oe === 1'b1);
        tick();
        ok &= (clk_oe === 1'b0) && (data_oe === 1'b1);
        check("inhibit_req_seq", 32'(ok), 32'd1);
        tick(10);
        for (int k = 0; k < 11; k++) begin
            frame[k] = kbd_data_line;
            if (k == 10 && v.ack) begin
                dev_data_low = 1'b1;
                tick(5);
            end
            dev_clk_low = 1'b1;
            if (v.inject && k == 3) begin
                tx_data  = 8'h55;
                tx_start = 1'b1;
                tick();
                tx_start = 1'b0;
                tick(19);
            end else begin
                tick(20);
            end
            dev_clk_low = 1'b0;
            tick(20);
        end
        tick(5);
        dev_data_low = 1'b0;
        for (int i = 0; i < 100 && busy !== 1'b0; i++) tick();
        check("busy_clear", 32'(busy), 32'd0);
        tick(10);
        exp_frame = {1'b1, v.exp_par, v.data, 1'b0};
        check("frame_bits", 32'(frame), 32'(exp_frame));
        check("done_pulses", 32'(n_done - d0), v.ack ? 32'd1 : 32'd0);
        check("ackerr_pulses", 32'(n_err - e0), v.ack ? 32'd0 : 32'd1);
        check("lines_released", {30'd0, clk_oe, data_oe}, 32'd0);
    endtask

    initial begin
        int d0, e0, n;
        vecs[0] = '{CMD_SET_LEDS, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{8'h00,        1'b1, 1'b0, 1'b1};
        vecs[2] = '{CMD_RESET,    1'b1, 1'b0, 1'b1};
        vecs[3] = '{8'h01,        1'b1, 1'b0, 1'b0};
        vecs[4] = '{CMD_ECHO,     1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'hA5,        1'b1, 1'b1, 1'b1};

        tick(3);
        check("rst_clk_oe", 32'(clk_oe), 32'd0);
        check("rst_data_oe", 32'(data_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ack_err", 32'(ack_err), 32'd0);
        rst = 1'b1;
        tick(3);
        check("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Device never clocks: watchdog fires TMO cycles after clock release.
        d0 = n_done;
        e0 = n_err;
        tx_data  = CMD_RESET;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        tick(INH + 1);
        check("tmo_clk_released", 32'(clk_oe), 32'd0);
        n = 0;
        while (ack_err !== 1'b1 && n < int'(TMO) + 100) begin
            tick();
            n++;
        end
        check("tmo_cycles", 32'(n), 32'(TMO));
        check("tmo_busy", 32'(busy), 32'd0);
        check("tmo_lines", {30'd0, clk_oe, data_oe}, 32'd0);
        tick(5);
        check("tmo_err_pulses", 32'(n_err - e0), 32'd1);
        check("tmo_done_pulses", 32'(n_done - d0), 32'd0);

        // Reset in the middle of data bit D4.
        d0 = n_done;
        e0 = n_err;
        tx_data  = 8'h00;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        tick(INH + 1);
        tick(10);
        for (int k = 0; k < 5; k++) begin
            dev_clk_low = 1'b1;
            tick(20);
            dev_clk_low = 1'b0;
            tick(20);
        end
        check("pre_rst_data_oe", 32'(data_oe), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_lines", {30'd0, clk_oe, data_oe}, 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        tick(3);
        rst = 1'b1;
        tick(50);
        check("rst_no_pulses", 32'((n_done - d0) + (n_err - e0)), 32'd0);
        run_vec('{CMD_RESET, 1'b1, 1'b0, 1'b1});

        check("done_and_err_overlap", 32'(n_both), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
